// File: rtl/iserdes_word_aligner_if.sv
`default_nettype none
// ============================================================================
// Module   : iserdes_word_aligner_if
// Brief    : Capture-side and aligned-word signals of the ISERDES word aligner.
// Revision : 1.0 - initial release
// ============================================================================
interface iserdes_word_aligner_if #(
  parameter int NUM_LANES = 1,
  parameter int HALF_W    = 6
);
  localparam int c_word_w = 2 * HALF_W;
  localparam int c_sw     = $clog2(c_word_w);

  logic                          train_en;
  logic [NUM_LANES*HALF_W-1:0]   data_a;
  logic [NUM_LANES*HALF_W-1:0]   data_b;
  logic [NUM_LANES*c_word_w-1:0] word_out;
  logic                          word_valid;
  logic [NUM_LANES-1:0]          lane_locked;
  logic                          all_locked;
  logic [NUM_LANES*c_sw-1:0]     slip_count;
  logic [NUM_LANES*16-1:0]       err_count;

  modport master (
    output train_en, data_a, data_b,
    input  word_out, word_valid, lane_locked, all_locked, slip_count, err_count
  );

  modport slave (
    input  train_en, data_a, data_b,
    output word_out, word_valid, lane_locked, all_locked, slip_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/iserdes_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : iserdes_word_aligner
// Brief    : Per-lane A/B interleave, barrel bitslip and training-pattern lock.
//            Optional mismatch counters enabled by macro ALIGN_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iserdes_word_aligner #(
  parameter int                  NUM_LANES     = 1,
  parameter int                  HALF_W        = 6,
  parameter logic [2*HALF_W-1:0] TRAIN_PATTERN = 12'hF00,
  parameter int                  LOCK_CNT      = 16,
  parameter int                  SLIP_WAIT     = 4,
  parameter int                  LOSS_CNT      = 4
) (
  input logic                   clk,
  input logic                   rst,
  iserdes_word_aligner_if.slave bus
);
  localparam int c_word_w = 2 * HALF_W;
  localparam int c_sw     = $clog2(c_word_w);
  localparam int c_cw     = $clog2(2 * c_word_w);
  localparam int c_mw     = $clog2(LOCK_CNT + 1);
  localparam int c_ww     = $clog2(SLIP_WAIT + 1);
  localparam int c_lw     = $clog2(LOSS_CNT + 1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_check  = 3'd1;
  localparam logic [2:0] c_slip   = 3'd2;
  localparam logic [2:0] c_wait   = 3'd3;
  localparam logic [2:0] c_locked = 3'd4;

  localparam logic [c_sw-1:0] c_slip_max  = c_sw'(c_word_w - 1);
  localparam logic [c_mw-1:0] c_lock_last = c_mw'(LOCK_CNT - 1);
  localparam logic [c_ww-1:0] c_wait_init = c_ww'(SLIP_WAIT);
  localparam logic [c_ww-1:0] c_wait_last = c_ww'(1);
  localparam logic [c_lw-1:0] c_loss_last = c_lw'(LOSS_CNT - 1);

  logic [NUM_LANES-1:0][c_word_w-1:0] w_word_all;
  logic [NUM_LANES-1:0][c_sw-1:0]     w_slip_all;
  logic [NUM_LANES-1:0][15:0]         w_err_all;
  logic [NUM_LANES-1:0]               w_locked_all;
  logic                               r_all_locked;

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [c_word_w-1:0]   w_raw_next;
      logic [c_word_w-1:0]   r_raw;
      logic [c_word_w-1:0]   r_cur;
      logic [c_word_w-1:0]   r_prev;
      logic [c_word_w-1:0]   r_word;
      logic [2*c_word_w-1:0] w_cat;
      logic [c_cw-1:0]       w_idx;
      logic [c_word_w-1:0]   w_aligned;
      logic                  w_match;
      logic [2:0]            r_state;
      logic [c_sw-1:0]       r_slip;
      logic [c_mw-1:0]       r_match_cnt;
      logic [c_ww-1:0]       r_wait_cnt;
      logic [c_lw-1:0]       r_miss_cnt;
      logic                  r_locked;

      // B half is captured on the inverted clock phase, so its polarity is flipped.
      always_comb begin
        w_raw_next = '0;
        for (int i = 0; i < HALF_W; i++) begin
          w_raw_next[2*i+1] = bus.data_a[l*HALF_W + i];
          w_raw_next[2*i]   = ~bus.data_b[l*HALF_W + i];
        end
      end

      assign w_cat     = {r_prev, r_cur};
      assign w_idx     = c_cw'(r_slip);
      assign w_aligned = w_cat[w_idx +: c_word_w];
      assign w_match   = (r_word == TRAIN_PATTERN);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_raw  <= '0;
          r_cur  <= '0;
          r_prev <= '0;
          r_word <= '0;
        end else begin
          r_raw  <= w_raw_next;
          r_cur  <= r_raw;
          r_prev <= r_cur;
          r_word <= w_aligned;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state     <= c_idle;
          r_slip      <= '0;
          r_match_cnt <= '0;
          r_wait_cnt  <= '0;
          r_miss_cnt  <= '0;
          r_locked    <= 1'b0;
        end else begin
          case (r_state)
            c_idle: begin
              if (bus.train_en) begin
                r_state     <= c_check;
                r_match_cnt <= '0;
              end
            end
            c_check: begin
              if (!bus.train_en) begin
                r_state <= c_idle;
              end else if (!w_match) begin
                r_state <= c_slip;
              end else if (r_match_cnt == c_lock_last) begin
                r_state    <= c_locked;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + 1'b1;
              end
            end
            c_slip: begin
              if (!bus.train_en) begin
                r_state <= c_idle;
              end else begin
                r_slip     <= (r_slip == c_slip_max) ? '0 : r_slip + 1'b1;
                r_state    <= c_wait;
                r_wait_cnt <= c_wait_init;
              end
            end
            c_wait: begin
              // The new offset needs a few cycles to flush through word_out.
              if (!bus.train_en) begin
                r_state <= c_idle;
              end else begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
                if (r_wait_cnt == c_wait_last) begin
                  r_state     <= c_check;
                  r_match_cnt <= '0;
                end
              end
            end
            c_locked: begin
              if (bus.train_en) begin
                if (w_match) begin
                  r_miss_cnt <= '0;
                end else if (r_miss_cnt == c_loss_last) begin
                  r_state     <= c_check;
                  r_match_cnt <= '0;
                  r_locked    <= 1'b0;
                end else begin
                  r_miss_cnt <= r_miss_cnt + 1'b1;
                end
              end
            end
            default: r_state <= c_idle;
          endcase
        end
      end

`ifdef ALIGN_ERR_CNT_EN
      logic [15:0] r_err_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_err_cnt <= '0;
        end else if (r_state == c_idle && bus.train_en) begin
          r_err_cnt <= '0;
        end else if (r_state == c_locked && bus.train_en && !w_match &&
                     r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end

      assign w_err_all[l] = r_err_cnt;
`else
      assign w_err_all[l] = 16'h0000;
`endif

      assign w_word_all[l]   = r_word;
      assign w_slip_all[l]   = r_slip;
      assign w_locked_all[l] = r_locked;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_all_locked <= 1'b0;
    end else begin
      r_all_locked <= &w_locked_all;
    end
  end

  assign bus.word_out    = w_word_all;
  assign bus.slip_count  = w_slip_all;
  assign bus.err_count   = w_err_all;
  assign bus.lane_locked = w_locked_all;
  assign bus.all_locked  = r_all_locked;
  assign bus.word_valid  = r_all_locked;
endmodule
`default_nettype wire

// File: tb/tb_iserdes_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_iserdes_word_aligner
// Brief    : Self-checking bench for the 1-lane and 4-lane aligner builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iserdes_word_aligner;
  localparam int          c_hw    = 6;
  localparam logic [11:0] c_train = 12'hF00;
`ifdef ALIGN_ERR_CNT_EN
  localparam logic [15:0] c_exp_err = 16'd7;
`else
  localparam logic [15:0] c_exp_err = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  iserdes_word_aligner_if #(.NUM_LANES(1), .HALF_W(c_hw)) if1 ();
  iserdes_word_aligner_if #(.NUM_LANES(4), .HALF_W(c_hw)) if4 ();

  iserdes_word_aligner #(.NUM_LANES(1), .HALF_W(c_hw)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  iserdes_word_aligner #(.NUM_LANES(4), .HALF_W(c_hw)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] exp_word;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] rotl(input logic [11:0] w, input int k);
    logic [23:0] t;
    t = {w, w} << k;
    return t[23:12];
  endfunction

  // Word seen at offset s when hi is the older word and lo the newer one.
  function automatic logic [11:0] window(input logic [11:0] hi, input logic [11:0] lo, input int s);
    logic [23:0] t;
    t = {hi, lo} >> s;
    return t[11:0];
  endfunction

  function automatic logic [5:0] raw_a(input logic [11:0] r);
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = r[2*i+1];
    return v;
  endfunction

  function automatic logic [5:0] raw_b(input logic [11:0] r);
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = ~r[2*i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [11:0] r);
    if1.data_a = raw_a(r);
    if1.data_b = raw_b(r);
  endtask

  task automatic drive4(input logic [3:0][11:0] r);
    for (int l = 0; l < 4; l++) begin
      if4.data_a[l*6 +: 6] = raw_a(r[l]);
      if4.data_b[l*6 +: 6] = raw_b(r[l]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t              vecs[8];
    logic [11:0]       q[$];
    logic [11:0]       r;
    logic [3:0][11:0]  w4;
    int                k[4];
    int                lock_t[4];
    int                all_t;
    int                cyc;
    int                prev;
    int                cur;
    int                wraps;
    logic              flag;
    logic              vmis;
    logic [15:0]       exp_slip;

    vecs[0] = '{6'h3F, 6'h00, 12'hFFF};
    vecs[1] = '{6'h00, 6'h3F, 12'h000};
    vecs[2] = '{6'h38, 6'h3F, 12'hA80};
    vecs[3] = '{6'h30, 6'h0F, 12'hF00};
    vecs[4] = '{6'h15, 6'h3F, 12'h222};
    vecs[5] = '{6'h00, 6'h2A, 12'h111};
    vecs[6] = '{6'h3F, 6'h3F, 12'hAAA};
    vecs[7] = '{6'h00, 6'h00, 12'h555};

    rst = 1'b1;
    if1.train_en = 1'b0;
    if4.train_en = 1'b0;
    drive1(12'h000);
    drive4('0);
    tick();
    tick();
    check("reset_word_out", if1.word_out, 0);
    check("reset_lane_locked", if1.lane_locked, 0);
    check("reset_slip", if1.slip_count, 0);
    check("reset_word_valid", if1.word_valid, 0);
    check("reset_err", if1.err_count, 0);
    rst = 1'b0;
    tick();

    // Interleave/inversion with zero offset, training disabled
    for (int i = 0; i < 8; i++) begin
      if1.data_a = vecs[i].a;
      if1.data_b = vecs[i].b;
      repeat (3) tick();
      check($sformatf("vec%0d_word_out", i), if1.word_out, vecs[i].exp_word);
    end

    // Already-aligned stream locks at offset 0
    drive1(c_train);
    repeat (4) tick();
    if1.train_en = 1'b1;
    cyc = 0;
    while (!if1.lane_locked && cyc < 20) begin
      tick();
      cyc++;
    end
    check("aligned_lock", if1.lane_locked, 1);
    check("aligned_slip", if1.slip_count, 0);
    check("aligned_word", if1.word_out, c_train);
    check("aligned_all_same_cycle", if1.all_locked, 0);
    tick();
    check("aligned_all_next", if1.all_locked, 1);
    check("aligned_valid_next", if1.word_valid, 1);

    // Three misses then a match keep lock; four consecutive misses drop it
    drive1(12'h0F0);
    repeat (3) tick();
    drive1(c_train);
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (!if1.lane_locked) flag = 1'b1;
    end
    check("loss_3miss_hold", flag, 0);
    drive1(12'h0F0);
    repeat (4) tick();
    drive1(c_train);
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (!if1.lane_locked) flag = 1'b1;
    end
    check("loss_4miss_drop", flag, 1);
    check("loss_err_count", if1.err_count, c_exp_err);
    cyc = 0;
    while (!if1.lane_locked && cyc < 30) begin
      tick();
      cyc++;
    end
    check("loss_relock", if1.lane_locked, 1);
    check("loss_relock_slip", if1.slip_count, 0);

    // Stream rotated so that offset 5 recovers the training word
    if1.train_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive1(rotl(c_train, 5));
    repeat (4) tick();
    check("rot5_raw_at_s0", if1.word_out, rotl(c_train, 5));
    if1.train_en = 1'b1;
    cyc = 0;
    while (!if1.lane_locked && cyc < 300) begin
      tick();
      cyc++;
    end
    check("rot5_lock", if1.lane_locked, 1);
    check("rot5_slip", if1.slip_count, 5);
    check("rot5_word", if1.word_out, c_train);

    // Random data through the frozen offset-5 window, lock held with training off
    if1.train_en = 1'b0;
    q = {rotl(c_train, 5), rotl(c_train, 5), rotl(c_train, 5)};
    flag = 1'b1;
    repeat (40) begin
      r = 12'($urandom);
      drive1(r);
      tick();
      q.push_back(r);
      check("rand_path_word", if1.word_out, window(q[q.size()-4], q[q.size()-3], 5));
      if (!if1.lane_locked || !if1.word_valid) flag = 1'b0;
    end
    check("rand_path_lock_held", flag, 1);
    check("rand_path_slip_held", if1.slip_count, 5);

    // Garbage never locks; offset steps by one and wraps 11 -> 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive1(12'hFFF);
    repeat (4) tick();
    check("garbage_word", if1.word_out, 12'hFFF);
    if1.train_en = 1'b1;
    prev = 0;
    wraps = 0;
    flag = 1'b0;
    repeat (250) begin
      tick();
      cur = int'(if1.slip_count);
      if (cur != prev) begin
        check("wrap_step", cur, (prev == 11) ? 0 : prev + 1);
        if (prev == 11) wraps++;
        prev = cur;
      end
      if (if1.lane_locked) flag = 1'b1;
    end
    check("garbage_never_locked", flag, 0);
    check("garbage_wraps", wraps >= 2, 1);

    // Asynchronous reset in the middle of a search at offset 3
    cyc = 0;
    while (if1.slip_count != 3 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("midsearch_reach_s3", if1.slip_count, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_word_out", if1.word_out, 0);
    check("async_rst_slip", if1.slip_count, 0);
    check("async_rst_locked", if1.lane_locked, 0);
    check("async_rst_valid", if1.word_valid, 0);
    if1.train_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_slip", if1.slip_count, 0);

    // Four lanes at offsets 0, 2, 7, 11
    k = '{0, 2, 7, 11};
    for (int l = 0; l < 4; l++) w4[l] = rotl(c_train, k[l]);
    drive4(w4);
    repeat (4) tick();
    if4.train_en = 1'b1;
    lock_t = '{-1, -1, -1, -1};
    all_t = -1;
    vmis = 1'b0;
    for (int c = 1; c <= 400 && all_t < 0; c++) begin
      tick();
      for (int l = 0; l < 4; l++)
        if (lock_t[l] < 0 && if4.lane_locked[l]) lock_t[l] = c;
      if (if4.all_locked) all_t = c;
      if (if4.word_valid !== if4.all_locked) vmis = 1'b1;
    end
    for (int l = 0; l < 4; l++)
      check($sformatf("ml_lane%0d_locked", l), lock_t[l] >= 0, 1);
    check("ml_lane0_before_lane1", lock_t[0] < lock_t[1], 1);
    check("ml_lane1_before_lane2", lock_t[1] < lock_t[2], 1);
    check("ml_lane2_before_lane3", lock_t[2] < lock_t[3], 1);
    check("ml_all_locked_time", all_t, lock_t[3] + 1);
    check("ml_valid_tracks_all", vmis, 0);
    check("ml_slip_count", if4.slip_count, 16'hB720);
    check("ml_word_out", if4.word_out, {4{c_train}});

    // Random re-targeting: lanes drop lock and search onward (wrapping) to the new offset
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int l = 0; l < 4; l++) begin
        k[l] = int'($urandom_range(0, 11));
        w4[l] = rotl(c_train, k[l]);
      end
      drive4(w4);
      repeat (12) tick();
      cyc = 0;
      while (!if4.all_locked && cyc < 600) begin
        tick();
        cyc++;
      end
      exp_slip = 16'({4'(k[3]), 4'(k[2]), 4'(k[1]), 4'(k[0])});
      check($sformatf("rnd%0d_all_locked", rnd), if4.all_locked, 1);
      check($sformatf("rnd%0d_slip_count", rnd), if4.slip_count, exp_slip);
      check($sformatf("rnd%0d_word_out", rnd), if4.word_out, {4{c_train}});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
